// File: rtl/sap2_pkg.sv
// ============================================================================
// Module  : sap2_pkg
// Brief   : Shared SAP-2 constants: program counter width and reset address.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sap2_pkg;
  localparam int              PC_ADDR_W     = 16;
  localparam logic [15:0]     PC_RESET_ADDR = 16'h0000;
endpackage

`default_nettype wire

// File: rtl/return_stack_if.sv
// ============================================================================
// Module  : return_stack_if
// Brief   : Control-unit / PC-load-path bundle for the return stack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface return_stack_if #(
  parameter int ADDR_W = sap2_pkg::PC_ADDR_W,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] target;
  logic              clr_err;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_data;
  logic [ADDR_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output call, ret, pc_in, target, clr_err,
    input  pc_load, pc_data, top, count, full, empty, overflow, underflow
  );

  modport slave (
    input  call, ret, pc_in, target, clr_err,
    output pc_load, pc_data, top, count, full, empty, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/return_stack_mem.sv
// ============================================================================
// Module  : return_stack_mem
// Brief   : DEPTH x ADDR_W register array, synchronous write, async read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module return_stack_mem #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  wire logic                     clk,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [ADDR_W-1:0]        wdata_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output      logic [ADDR_W-1:0]        rdata_o
);
  logic [ADDR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

`default_nettype wire

// File: rtl/return_stack.sv
// ============================================================================
// Module  : return_stack
// Brief   : CALL/RET address stack driving the PC load path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module return_stack
  import sap2_pkg::*;
#(
  parameter int ADDR_W = sap2_pkg::PC_ADDR_W,
  parameter int DEPTH  = 8
) (
  input wire logic      clk,
  input wire logic      rst,
  return_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_data_q, pc_data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we;
  logic [IDX_W-1:0]  waddr, raddr;
  logic [ADDR_W-1:0] rdata;
  logic              full, empty;

  assign full  = (count_q == C_FULL);
  assign empty = (count_q == '0);
  assign raddr = empty ? '0 : IDX_W'(count_q - C_ONE);

  return_stack_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(bus.pc_in),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  always_comb begin
    count_d   = count_q;
    pc_load_d = 1'b0;
    pc_data_d = pc_data_q;
    ovf_d     = bus.clr_err ? 1'b0 : ovf_q;
    unf_d     = bus.clr_err ? 1'b0 : unf_q;
    we        = 1'b0;
    waddr     = IDX_W'(count_q);
    unique case ({bus.call, bus.ret})
      2'b10: begin
        pc_load_d = 1'b1;
        pc_data_d = bus.target;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + C_ONE;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pc_load_d = 1'b1;
          pc_data_d = rdata;
          count_d   = count_q - C_ONE;
        end
      end
      2'b11: begin
        // Pop-then-push: overwrite the top in place; empty degrades to a push.
        pc_load_d = 1'b1;
        pc_data_d = bus.target;
        we        = 1'b1;
        if (empty) begin
          waddr   = '0;
          count_d = C_ONE;
          unf_d   = 1'b1;
        end else begin
          waddr = raddr;
        end
      end
      default: ;
    endcase
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      pc_load_q <= 1'b0;
      pc_data_q <= ADDR_W'(PC_RESET_ADDR);
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pc_load_q <= pc_load_d;
      pc_data_q <= pc_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.pc_load   = pc_load_q;
  assign bus.pc_data   = pc_data_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.top       = empty ? '0 : rdata;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// ============================================================================
// Module  : tb_return_stack
// Brief   : Directed vector bench for return_stack (ADDR_W=16, DEPTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_return_stack;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  return_stack_if #(.ADDR_W(16), .DEPTH(8)) bus ();

  return_stack #(.ADDR_W(16), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        call, ret, clr, rs;
    logic [15:0] pc, tgt;
    logic        ld;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] top;
    logic        full, empty, ovf, unf;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [40:0] observed();
    return {bus.pc_load, bus.pc_data, bus.count, bus.top,
            bus.full, bus.empty, bus.overflow, bus.underflow};
  endfunction

  task automatic apply(input logic c, input logic r, input logic cl, input logic rs,
                       input logic [15:0] pc, input logic [15:0] tgt);
    @(negedge clk);
    bus.call = c; bus.ret = r; bus.clr_err = cl; rst = rs;
    bus.pc_in = pc; bus.target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [40:0] exp);
    logic [40:0] act;
    act = observed();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {ld,data,cnt,top,full,empty,ovf,unf}=%h required %h",
                  name, act, exp);
  endtask

  initial begin
    // call ret clr rst   pc      tgt       ld  data     cnt    top    full empty ovf unf
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 16'h0000,16'h0000, 1'b0,16'h0000,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 16'h0012,16'h0400, 1'b1,16'h0400,4'd1,16'h0012, 1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,16'h0400,4'd1,16'h0012, 1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,16'h0012,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,16'h0012,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h0000, 1'b0,16'h0012,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0, 16'h0000,16'h0000, 1'b0,16'h0012,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0, 16'h0000,16'h0000, 1'b0,16'h0012,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 16'h0010,16'h0300, 1'b1,16'h0300,4'd1,16'h0010, 1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 16'h0020,16'h0310, 1'b1,16'h0310,4'd2,16'h0020, 1'b0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 16'h0030,16'h0500, 1'b1,16'h0500,4'd2,16'h0030, 1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,16'h0030,4'd1,16'h0010, 1'b0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,16'h0010,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b0, 16'h0055,16'h0600, 1'b1,16'h0600,4'd1,16'h0055, 1'b0,1'b0,1'b0,1'b1};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0, 16'h0000,16'h0000, 1'b1,16'h0055,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0, 16'h0042,16'h0700, 1'b1,16'h0700,4'd1,16'h0042, 1'b0,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000, 1'b1,16'h0042,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0, 16'h0001,16'h0011, 1'b1,16'h0011,4'd1,16'h0001, 1'b0,1'b0,1'b0,1'b0};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0, 16'h0002,16'h0012, 1'b1,16'h0012,4'd2,16'h0002, 1'b0,1'b0,1'b0,1'b0};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0, 16'h0003,16'h0013, 1'b1,16'h0013,4'd3,16'h0003, 1'b0,1'b0,1'b0,1'b0};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b1, 16'h0004,16'h0014, 1'b0,16'h0000,4'd0,16'h0000, 1'b0,1'b1,1'b0,1'b0};

    rst = 1'b1;
    bus.call = 1'b0; bus.ret = 1'b0; bus.clr_err = 1'b0;
    bus.pc_in = '0; bus.target = '0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].rs, vecs[i].pc, vecs[i].tgt);
      check($sformatf("vec%0d", i),
            {vecs[i].ld, vecs[i].data, vecs[i].cnt, vecs[i].top,
             vecs[i].full, vecs[i].empty, vecs[i].ovf, vecs[i].unf});
    end

    // Fill to DEPTH, overflow (also with clr_err in the same cycle), then drain.
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i), 16'(16'h0200 + i));
      check($sformatf("push%0d", i),
            {1'b1, 16'(16'h0200 + i), 4'(i + 1), 16'(16'h0100 + i),
             (i == 7), 1'b0, 1'b0, 1'b0});
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0199, 16'h0ABC);
    check("overflow_call", {1'b1, 16'h0ABC, 4'd8, 16'h0107, 1'b1, 1'b0, 1'b1, 1'b0});
    apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0198, 16'h0ABD);
    check("overflow_vs_clr", {1'b1, 16'h0ABD, 4'd8, 16'h0107, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check($sformatf("pop%0d", i),
            {1'b1, 16'(16'h0107 - i), 4'(7 - i),
             (i < 7) ? 16'(16'h0106 - i) : 16'h0000,
             1'b0, (i == 7), 1'b1, 1'b0});
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("clr_overflow", {1'b0, 16'h0100, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
